// File: rtl/gck_pkg.sv
// Shared definitions for the clock-gate controller: FSM encoding,
// legal parameter bounds and the counter widths derived from them.
package gck_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } gck_state_e;

  localparam int IDLE_TH_MIN  = 2;
  localparam int IDLE_TH_MAX  = 255;
  localparam int WAKE_LAT_MIN = 1;
  localparam int WAKE_LAT_MAX = 15;

  // Sized for the largest legal parameter so any setting fits.
  localparam int IDLE_CNT_W = $clog2(IDLE_TH_MAX + 1);
  localparam int WAKE_CNT_W = $clog2(WAKE_LAT_MAX + 1);

  localparam int EVT_W = 16;

endpackage

// File: rtl/gck_sat_cnt.sv
// 16-bit event counter that sticks at all-ones; synchronous clear wins
// over increment.
module gck_sat_cnt
  import gck_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [EVT_W-1:0] cnt_o
);

  logic [EVT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {EVT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gate controller: drops clk_en after IDLE_TH quiet
// cycles and brings the clock back with a WAKE_LAT settle before rdy.
module clk_gate_ctrl
  import gck_pkg::*;
#(
  parameter int IDLE_TH  = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        req,
  input  logic        force_on,
  output logic        clk_en,
  output logic        rdy,
  output logic        gated,
  output logic [15:0] gate_events
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_TH - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_LAT - 1);

  gck_state_e            state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                  clk_en_q, clk_en_d;
  logic                  rdy_q, rdy_d;
  logic                  gated_q, gated_d;
  logic                  act;
  logic                  gate_inc;

  always_comb begin
    act        = busy | req | force_on;
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_inc   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!act) begin
          state_d    = ST_IDLE;
          idle_cnt_d = IDLE_CNT_W'(1);
        end
      end
      ST_IDLE: begin
        // Activity beats the threshold when both land on the same edge.
        if (act) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = ST_GATED;
          idle_cnt_d = '0;
          gate_inc   = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_GATED: begin
        if (act) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // Wake always runs to completion; activity is not sampled here.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    clk_en_d = (state_d != ST_GATED);
    rdy_d    = (state_d == ST_RUN) || (state_d == ST_IDLE);
    gated_d  = (state_d == ST_GATED);
  end

  // Outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      clk_en_q   <= 1'b1;
      rdy_q      <= 1'b1;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= clk_en_d;
      rdy_q      <= rdy_d;
      gated_q    <= gated_d;
    end
  end

  gck_sat_cnt u_evt_cnt (
    .clk_i (clk),
    .clr_i (~rst_n),
    .inc_i (gate_inc),
    .cnt_o (gate_events)
  );

  assign clk_en = clk_en_q;
  assign rdy    = rdy_q;
  assign gated  = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed and randomized bench for clk_gate_ctrl against a cycle-count
// reference model, plus a standalone saturation run of gck_sat_cnt.
module tb_clk_gate_ctrl;

  localparam int TH = 8;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy = 1'b0;
  logic        req = 1'b0;
  logic        force_on = 1'b0;
  logic        clk_en;
  logic        rdy;
  logic        gated;
  logic [15:0] gate_events;

  logic        sc_clr = 1'b1;
  logic        sc_inc = 1'b0;
  logic [15:0] sc_cnt;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Reference model: gated flag, edges left until rdy, quiet-run length.
  bit m_gated;
  int m_wake_left;
  int m_inact;
  int m_events;

  always #5 clk = ~clk;

  clk_gate_ctrl #(.IDLE_TH(TH), .WAKE_LAT(WL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (busy),
    .req         (req),
    .force_on    (force_on),
    .clk_en      (clk_en),
    .rdy         (rdy),
    .gated       (gated),
    .gate_events (gate_events)
  );

  gck_sat_cnt u_sat (
    .clk_i (clk),
    .clr_i (sc_clr),
    .inc_i (sc_inc),
    .cnt_o (sc_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit act, input bit rn);
    if (!rn) begin
      m_gated = 0; m_wake_left = 0; m_inact = 0; m_events = 0;
    end else if (m_wake_left > 0) begin
      m_wake_left--;
    end else if (m_gated) begin
      if (act) begin
        m_gated = 0;
        m_wake_left = WL;
      end
    end else begin
      m_inact = act ? 0 : m_inact + 1;
      if (m_inact == TH) begin
        m_gated = 1;
        m_inact = 0;
        if (m_events < 65535) m_events++;
      end
    end
  endtask

  task automatic tick(input bit b, input bit r, input bit f, input bit rn);
    busy = b; req = r; force_on = f; rst_n = rn;
    @(posedge clk);
    model_edge(b | r | f, rn);
    #1;
    chk("clk_en", {15'd0, clk_en}, {15'd0, !m_gated});
    chk("rdy", {15'd0, rdy}, {15'd0, (!m_gated && m_wake_left == 0)});
    chk("gated", {15'd0, gated}, {15'd0, m_gated});
    chk("gate_events", gate_events, 16'(m_events));
  endtask

  initial begin
    int sc_model;

    phase = "reset";
    repeat (3) tick(0, 0, 0, 0);
    chk("reset_rdy", {15'd0, rdy}, 16'd1);

    phase = "idle_to_gated";
    repeat (TH - 1) tick(0, 0, 0, 1);
    chk("still_enabled", {15'd0, clk_en}, 16'd1);
    tick(0, 0, 0, 1);
    chk("gated_now", {15'd0, gated}, 16'd1);
    chk("first_event", gate_events, 16'd1);

    phase = "wake";
    tick(0, 1, 0, 1);
    chk("wake_clk_en", {15'd0, clk_en}, 16'd1);
    tick(0, 0, 0, 1);
    chk("wake_not_rdy", {15'd0, rdy}, 16'd0);
    tick(0, 0, 0, 1);
    chk("wake_rdy", {15'd0, rdy}, 16'd1);

    phase = "late_activity";
    tick(0, 0, 0, 0);
    repeat (TH - 1) tick(0, 0, 0, 1);
    tick(1, 0, 0, 1);
    repeat (TH - 1) tick(0, 0, 0, 1);
    chk("no_gate", gate_events, 16'd0);
    chk("kept_enabled", {15'd0, clk_en}, 16'd1);

    phase = "force_on";
    tick(0, 0, 0, 0);
    repeat (1000) tick(0, 0, 1, 1);
    chk("force_events", gate_events, 16'd0);

    phase = "reset_in_wake";
    repeat (TH) tick(0, 0, 0, 1);
    tick(1, 0, 0, 1);
    chk("in_wake", {15'd0, rdy}, 16'd0);
    tick(0, 0, 0, 0);
    chk("rst_clk_en", {15'd0, clk_en}, 16'd1);
    chk("rst_rdy", {15'd0, rdy}, 16'd1);
    chk("rst_events", gate_events, 16'd0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 399) != 0);
    end

    phase = "saturate";
    sc_clr = 1'b1; sc_inc = 1'b0;
    @(posedge clk); #1;
    chk("sat_clear", sc_cnt, 16'd0);
    sc_clr = 1'b0; sc_inc = 1'b1;
    sc_model = 0;
    for (int n = 1; n <= 65537; n++) begin
      @(posedge clk);
      if (sc_model < 65535) sc_model++;
      #1;
      if (n == 1 || n == 65534 || n == 65535 || n == 65537)
        chk("sat_count", sc_cnt, 16'(sc_model));
    end
    sc_inc = 1'b0; sc_clr = 1'b1;
    @(posedge clk); #1;
    chk("sat_reclear", sc_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
